// File: rtl/delay_axi_regs_if.sv
// rtl/delay_axi_regs_if.sv - AXI4-Lite bus bundle between the master and the delay register file
interface delay_axi_regs_if #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
);
  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic [2:0]                      S_AXI_AWPROT;
  logic                            S_AXI_AWVALID;
  logic                            S_AXI_AWREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                            S_AXI_WVALID;
  logic                            S_AXI_WREADY;
  logic [1:0]                      S_AXI_BRESP;
  logic                            S_AXI_BVALID;
  logic                            S_AXI_BREADY;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic [2:0]                      S_AXI_ARPROT;
  logic                            S_AXI_ARVALID;
  logic                            S_AXI_ARREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [1:0]                      S_AXI_RRESP;
  logic                            S_AXI_RVALID;
  logic                            S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );
endinterface

// File: rtl/delay_axi_regs.sv
// rtl/delay_axi_regs.sv - AXI4-Lite slave holding four delay-core config registers
// Optional macro DELAY_AXI_SLVERR_EN: accesses to unmapped words 4..7 answer SLVERR.
module delay_axi_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  delay_axi_regs_if.slave          s_axi,
  output logic [31:0]              cfg_reg0,
  output logic [31:0]              cfg_reg1,
  output logic [31:0]              cfg_reg2,
  output logic [31:0]              cfg_reg3,
  output logic [3:0]               cfg_wr_pulse
);

  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef DELAY_AXI_SLVERR_EN
  localparam logic [1:0] RESP_UNMAPPED = 2'b10;
`else
  localparam logic [1:0] RESP_UNMAPPED = 2'b00;
`endif

  typedef enum logic [1:0] {W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_RESP} rstate_t;

  wstate_t     r_wstate, w_wstate_nxt;
  rstate_t     r_rstate, w_rstate_nxt;

  logic        r_awready, r_wready, r_bvalid;
  logic [1:0]  r_bresp;
  logic [2:0]  r_aw_word;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [3:0]  r_wr_pulse;
  logic [31:0] r_cfg [4];

  logic        r_arready, r_rvalid;
  logic [31:0] r_rdata;
  logic [1:0]  r_rresp;

  logic        w_aw_hs, w_w_hs, w_ar_hs, w_commit;
  logic [2:0]  w_cm_word, w_ar_word;
  logic [31:0] w_cm_data;
  logic [3:0]  w_cm_strb;
  logic        w_unused;

  assign w_aw_hs   = s_axi.S_AXI_AWVALID && r_awready;
  assign w_w_hs    = s_axi.S_AXI_WVALID && r_wready;
  assign w_ar_hs   = s_axi.S_AXI_ARVALID && r_arready;
  assign w_ar_word = s_axi.S_AXI_ARADDR[4:2];
  assign w_unused  = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                       s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

  // A channel handshaking on the commit edge wins over the (empty) holding register
  assign w_cm_word = w_aw_hs ? s_axi.S_AXI_AWADDR[4:2] : r_aw_word;
  assign w_cm_data = w_w_hs ? s_axi.S_AXI_WDATA : r_wdata;
  assign w_cm_strb = w_w_hs ? s_axi.S_AXI_WSTRB : r_wstrb;

  always_comb begin
    w_wstate_nxt = r_wstate;
    w_commit     = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        if (w_aw_hs && w_w_hs) begin
          w_wstate_nxt = W_RESP;
          w_commit     = 1'b1;
        end else if (w_aw_hs) begin
          w_wstate_nxt = W_HAVE_ADDR;
        end else if (w_w_hs) begin
          w_wstate_nxt = W_HAVE_DATA;
        end
      end
      W_HAVE_ADDR: begin
        if (w_w_hs) begin
          w_wstate_nxt = W_RESP;
          w_commit     = 1'b1;
        end
      end
      W_HAVE_DATA: begin
        if (w_aw_hs) begin
          w_wstate_nxt = W_RESP;
          w_commit     = 1'b1;
        end
      end
      default: begin
        if (s_axi.S_AXI_BREADY) w_wstate_nxt = W_IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_wstate   <= W_IDLE;
      r_awready  <= 1'b0;
      r_wready   <= 1'b0;
      r_bvalid   <= 1'b0;
      r_bresp    <= RESP_OKAY;
      r_aw_word  <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_wr_pulse <= '0;
      for (int i = 0; i < 4; i++) r_cfg[i] <= '0;
    end else begin
      r_wstate   <= w_wstate_nxt;
      r_awready  <= (w_wstate_nxt == W_IDLE) || (w_wstate_nxt == W_HAVE_DATA);
      r_wready   <= (w_wstate_nxt == W_IDLE) || (w_wstate_nxt == W_HAVE_ADDR);
      r_bvalid   <= (w_wstate_nxt == W_RESP);
      r_wr_pulse <= '0;
      if (w_aw_hs) r_aw_word <= s_axi.S_AXI_AWADDR[4:2];
      if (w_w_hs) begin
        r_wdata <= s_axi.S_AXI_WDATA;
        r_wstrb <= s_axi.S_AXI_WSTRB;
      end
      if (w_commit) begin
        if (!w_cm_word[2]) begin
          r_bresp                   <= RESP_OKAY;
          r_wr_pulse[w_cm_word[1:0]] <= 1'b1;
          for (int k = 0; k < 4; k++) begin
            if (w_cm_strb[k]) r_cfg[w_cm_word[1:0]][8*k +: 8] <= w_cm_data[8*k +: 8];
          end
        end else begin
          r_bresp <= RESP_UNMAPPED;
        end
      end
    end
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_RESP;
      default: if (s_axi.S_AXI_RREADY) w_rstate_nxt = R_IDLE;
    endcase
  end

  // Reads sample r_cfg before any same-edge write lands, so they see the old value
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
    end else begin
      r_rstate  <= w_rstate_nxt;
      r_arready <= (w_rstate_nxt == R_IDLE);
      r_rvalid  <= (w_rstate_nxt == R_RESP);
      if (w_ar_hs) begin
        if (!w_ar_word[2]) begin
          r_rdata <= r_cfg[w_ar_word[1:0]];
          r_rresp <= RESP_OKAY;
        end else begin
          r_rdata <= '0;
          r_rresp <= RESP_UNMAPPED;
        end
      end
    end
  end

  assign s_axi.S_AXI_AWREADY = r_awready;
  assign s_axi.S_AXI_WREADY  = r_wready;
  assign s_axi.S_AXI_BVALID  = r_bvalid;
  assign s_axi.S_AXI_BRESP   = r_bresp;
  assign s_axi.S_AXI_ARREADY = r_arready;
  assign s_axi.S_AXI_RVALID  = r_rvalid;
  assign s_axi.S_AXI_RDATA   = r_rdata;
  assign s_axi.S_AXI_RRESP   = r_rresp;

  assign cfg_reg0     = r_cfg[0];
  assign cfg_reg1     = r_cfg[1];
  assign cfg_reg2     = r_cfg[2];
  assign cfg_reg3     = r_cfg[3];
  assign cfg_wr_pulse = r_wr_pulse;

endmodule

// File: tb/tb_delay_axi_regs.sv
// tb/tb_delay_axi_regs.sv - directed self-checking bench for delay_axi_regs
module tb_delay_axi_regs;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [31:0] cfg_reg0, cfg_reg1, cfg_reg2, cfg_reg3;
  logic [3:0]  cfg_wr_pulse;
  logic [31:0] cfg [4];

  int errors = 0;
  int checks = 0;

  delay_axi_regs_if #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5)) axi ();

  delay_axi_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5)) dut (
    .ACLK         (ACLK),
    .ARESET       (ARESET),
    .s_axi        (axi.slave),
    .cfg_reg0     (cfg_reg0),
    .cfg_reg1     (cfg_reg1),
    .cfg_reg2     (cfg_reg2),
    .cfg_reg3     (cfg_reg3),
    .cfg_wr_pulse (cfg_wr_pulse)
  );

  always #5 ACLK = ~ACLK;

  assign cfg[0] = cfg_reg0;
  assign cfg[1] = cfg_reg1;
  assign cfg[2] = cfg_reg2;
  assign cfg[3] = cfg_reg3;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp, output logic [3:0] pulse_c,
                           output logic [3:0] pulse_n, output logic ok);
    logic aw_done, w_done, aw_go, w_go;
    aw_done = 1'b0;
    w_done  = 1'b0;
    axi.S_AXI_AWADDR  = addr;
    axi.S_AXI_WDATA   = data;
    axi.S_AXI_WSTRB   = strb;
    axi.S_AXI_AWVALID = 1'b1;
    axi.S_AXI_WVALID  = 1'b1;
    for (int i = 0; i < 20 && !(aw_done && w_done); i++) begin
      aw_go = axi.S_AXI_AWVALID && axi.S_AXI_AWREADY;
      w_go  = axi.S_AXI_WVALID && axi.S_AXI_WREADY;
      @(posedge ACLK); #1;
      if (aw_go) begin axi.S_AXI_AWVALID = 1'b0; aw_done = 1'b1; end
      if (w_go)  begin axi.S_AXI_WVALID  = 1'b0; w_done  = 1'b1; end
    end
    axi.S_AXI_AWVALID = 1'b0;
    axi.S_AXI_WVALID  = 1'b0;
    ok      = aw_done && w_done && axi.S_AXI_BVALID;
    resp    = axi.S_AXI_BRESP;
    pulse_c = cfg_wr_pulse;
    axi.S_AXI_BREADY = 1'b1;
    @(posedge ACLK); #1;
    axi.S_AXI_BREADY = 1'b0;
    pulse_n = cfg_wr_pulse;
  endtask

  task automatic axi_read(input logic [4:0] addr, output logic [31:0] data,
                          output logic [1:0] resp, output logic ok);
    logic done, go;
    done = 1'b0;
    axi.S_AXI_ARADDR  = addr;
    axi.S_AXI_ARVALID = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      go = axi.S_AXI_ARREADY;
      @(posedge ACLK); #1;
      if (go) done = 1'b1;
    end
    axi.S_AXI_ARVALID = 1'b0;
    ok   = done && axi.S_AXI_RVALID;
    data = axi.S_AXI_RDATA;
    resp = axi.S_AXI_RRESP;
    axi.S_AXI_RREADY = 1'b1;
    @(posedge ACLK); #1;
    axi.S_AXI_RREADY = 1'b0;
  endtask

  initial begin
    logic [31:0] wvals [4];
    logic [1:0]  resp, rresp, exp_err;
    logic [3:0]  pc, pn, onehot;
    logic [31:0] rd;
    logic        ok;

`ifdef DELAY_AXI_SLVERR_EN
    exp_err = 2'b10;
`else
    exp_err = 2'b00;
`endif
    wvals[0] = 32'h0101FFFF;
    wvals[1] = 32'hABCD0001;
    wvals[2] = 32'hDEAD0011;
    wvals[3] = 32'hBEEF0011;

    ARESET = 1'b1;
    axi.S_AXI_AWADDR = '0; axi.S_AXI_AWPROT = '0; axi.S_AXI_AWVALID = 1'b0;
    axi.S_AXI_WDATA  = '0; axi.S_AXI_WSTRB  = '0; axi.S_AXI_WVALID  = 1'b0;
    axi.S_AXI_BREADY = 1'b0;
    axi.S_AXI_ARADDR = '0; axi.S_AXI_ARPROT = '0; axi.S_AXI_ARVALID = 1'b0;
    axi.S_AXI_RREADY = 1'b0;

    repeat (2) @(posedge ACLK);
    #1;
    check("rst_awready", axi.S_AXI_AWREADY, 0);
    check("rst_wready",  axi.S_AXI_WREADY, 0);
    check("rst_arready", axi.S_AXI_ARREADY, 0);
    check("rst_bvalid",  axi.S_AXI_BVALID, 0);
    check("rst_rvalid",  axi.S_AXI_RVALID, 0);
    check("rst_rdata",   axi.S_AXI_RDATA, 0);
    check("rst_cfg0",    cfg_reg0, 0);
    check("rst_pulse",   cfg_wr_pulse, 0);

    ARESET = 1'b0;
    #1;
    check("rel_awready_low", axi.S_AXI_AWREADY, 0);
    @(posedge ACLK); #1;
    check("rel_awready", axi.S_AXI_AWREADY, 1);
    check("rel_wready",  axi.S_AXI_WREADY, 1);
    check("rel_arready", axi.S_AXI_ARREADY, 1);

    // write then read back each mapped word
    for (int i = 0; i < 4; i++) begin
      onehot = 4'b0001 << i;
      axi_write(5'(i * 4), wvals[i], 4'hF, resp, pc, pn, ok);
      check("wr_bvalid", ok, 1);
      check("wr_bresp", resp, 0);
      check("wr_pulse", pc, onehot);
      check("wr_pulse_clear", pn, 0);
      check("wr_cfg", cfg[i], wvals[i]);
      axi_read(5'(i * 4), rd, rresp, ok);
      check("rd_rvalid", ok, 1);
      check("rd_rresp", rresp, 0);
      check("rd_data", rd, wvals[i]);
    end

    // AW three cycles ahead of W
    axi.S_AXI_AWADDR  = 5'h04;
    axi.S_AXI_AWVALID = 1'b1;
    check("awfirst_ready", axi.S_AXI_AWREADY, 1);
    @(posedge ACLK); #1;
    axi.S_AXI_AWVALID = 1'b0;
    repeat (3) begin
      check("awfirst_awready_low", axi.S_AXI_AWREADY, 0);
      check("awfirst_no_bvalid", axi.S_AXI_BVALID, 0);
      @(posedge ACLK); #1;
    end
    axi.S_AXI_WDATA  = 32'h12345678;
    axi.S_AXI_WSTRB  = 4'hF;
    axi.S_AXI_WVALID = 1'b1;
    check("awfirst_wready", axi.S_AXI_WREADY, 1);
    @(posedge ACLK); #1;
    axi.S_AXI_WVALID = 1'b0;
    check("awfirst_cfg1", cfg_reg1, 32'h12345678);
    check("awfirst_bvalid", axi.S_AXI_BVALID, 1);
    check("awfirst_pulse", cfg_wr_pulse, 4'b0010);
    axi.S_AXI_BREADY = 1'b1;
    @(posedge ACLK); #1;
    axi.S_AXI_BREADY = 1'b0;
    check("awfirst_bvalid_clr", axi.S_AXI_BVALID, 0);
    check("awfirst_awready_back", axi.S_AXI_AWREADY, 1);

    // W three cycles ahead of AW
    axi.S_AXI_WDATA  = 32'hCAFEF00D;
    axi.S_AXI_WSTRB  = 4'hF;
    axi.S_AXI_WVALID = 1'b1;
    @(posedge ACLK); #1;
    axi.S_AXI_WVALID = 1'b0;
    repeat (3) begin
      check("wfirst_wready_low", axi.S_AXI_WREADY, 0);
      check("wfirst_no_bvalid", axi.S_AXI_BVALID, 0);
      @(posedge ACLK); #1;
    end
    check("wfirst_cfg1_held", cfg_reg1, 32'h12345678);
    axi.S_AXI_AWADDR  = 5'h04;
    axi.S_AXI_AWVALID = 1'b1;
    check("wfirst_awready", axi.S_AXI_AWREADY, 1);
    @(posedge ACLK); #1;
    axi.S_AXI_AWVALID = 1'b0;
    check("wfirst_cfg1", cfg_reg1, 32'hCAFEF00D);
    check("wfirst_bvalid", axi.S_AXI_BVALID, 1);
    check("wfirst_pulse", cfg_wr_pulse, 4'b0010);
    axi.S_AXI_BREADY = 1'b1;
    @(posedge ACLK); #1;
    axi.S_AXI_BREADY = 1'b0;

    // byte strobes: only bytes 0 and 2 change
    axi_write(5'h08, 32'hFFFFFFFF, 4'b0101, resp, pc, pn, ok);
    check("strb_bvalid", ok, 1);
    check("strb_cfg2", cfg_reg2, 32'hDEFF00FF);
    check("strb_pulse", pc, 4'b0100);

    // unmapped accesses
    axi_write(5'h10, 32'h5A5A5A5A, 4'hF, resp, pc, pn, ok);
    check("unm_bvalid", ok, 1);
    check("unm_bresp", resp, exp_err);
    check("unm_pulse", pc, 0);
    check("unm_cfg0", cfg_reg0, 32'h0101FFFF);
    check("unm_cfg1", cfg_reg1, 32'hCAFEF00D);
    check("unm_cfg2", cfg_reg2, 32'hDEFF00FF);
    check("unm_cfg3", cfg_reg3, 32'hBEEF0011);
    axi_read(5'h1C, rd, rresp, ok);
    check("unm_rvalid", ok, 1);
    check("unm_rresp", rresp, exp_err);
    check("unm_rdata", rd, 0);

    // same-word read and write together, responses stalled
    check("stall_ready_aw", axi.S_AXI_AWREADY, 1);
    check("stall_ready_ar", axi.S_AXI_ARREADY, 1);
    axi.S_AXI_AWADDR  = 5'h08;
    axi.S_AXI_WDATA   = 32'h11112222;
    axi.S_AXI_WSTRB   = 4'hF;
    axi.S_AXI_ARADDR  = 5'h08;
    axi.S_AXI_AWVALID = 1'b1;
    axi.S_AXI_WVALID  = 1'b1;
    axi.S_AXI_ARVALID = 1'b1;
    @(posedge ACLK); #1;
    axi.S_AXI_AWVALID = 1'b0;
    axi.S_AXI_WVALID  = 1'b0;
    axi.S_AXI_ARVALID = 1'b0;
    check("stall_cfg2", cfg_reg2, 32'h11112222);
    repeat (5) begin
      check("stall_bvalid", axi.S_AXI_BVALID, 1);
      check("stall_rvalid", axi.S_AXI_RVALID, 1);
      check("stall_rdata_old", axi.S_AXI_RDATA, 32'hDEFF00FF);
      check("stall_awready", axi.S_AXI_AWREADY, 0);
      check("stall_wready", axi.S_AXI_WREADY, 0);
      check("stall_arready", axi.S_AXI_ARREADY, 0);
      @(posedge ACLK); #1;
    end
    axi.S_AXI_BREADY = 1'b1;
    axi.S_AXI_RREADY = 1'b1;
    @(posedge ACLK); #1;
    axi.S_AXI_BREADY = 1'b0;
    axi.S_AXI_RREADY = 1'b0;
    check("stall_bvalid_clr", axi.S_AXI_BVALID, 0);
    check("stall_rvalid_clr", axi.S_AXI_RVALID, 0);

    // reset while a write response is pending
    axi.S_AXI_AWADDR  = 5'h0C;
    axi.S_AXI_WDATA   = 32'hBEEF0011;
    axi.S_AXI_WSTRB   = 4'hF;
    axi.S_AXI_AWVALID = 1'b1;
    axi.S_AXI_WVALID  = 1'b1;
    @(posedge ACLK); #1;
    axi.S_AXI_AWVALID = 1'b0;
    axi.S_AXI_WVALID  = 1'b0;
    check("mrst_bvalid_pre", axi.S_AXI_BVALID, 1);
    check("mrst_cfg3_pre", cfg_reg3, 32'hBEEF0011);
    ARESET = 1'b1;
    #1;
    check("mrst_bvalid", axi.S_AXI_BVALID, 0);
    check("mrst_cfg3", cfg_reg3, 0);
    check("mrst_awready", axi.S_AXI_AWREADY, 0);
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    #1;
    check("mrst_rel_wready_low", axi.S_AXI_WREADY, 0);
    @(posedge ACLK); #1;
    check("mrst_rel_awready", axi.S_AXI_AWREADY, 1);
    check("mrst_rel_wready", axi.S_AXI_WREADY, 1);
    check("mrst_rel_arready", axi.S_AXI_ARREADY, 1);
    check("mrst_rel_bvalid", axi.S_AXI_BVALID, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/delay_axi_regs.md
# delay_axi_regs

AXI4-Lite slave register file for the delay IP, sitting directly downstream of the AXI4-Lite master (BFM in simulation, PS interconnect in hardware). It accepts single-beat writes and reads, holds four 32-bit configuration registers and drives them, with per-register write strobes, to the delay core. Write address and write data channels are accepted independently, with one outstanding write and one outstanding read at a time.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 5, byte address width; decodes 8 word slots, of which 0..3 are mapped.
- ACLK  in  1  single clock; all logic is rising-edge.
- ARESET  in  1  asynchronous, active-high reset.
- S_AXI_AWADDR/AWPROT/AWVALID  in  ADDR/3/1  write address channel; AWPROT is ignored.
- S_AXI_AWREADY  out  1  write address ready.
- S_AXI_WDATA/WSTRB/WVALID  in  32/4/1  write data channel.
- S_AXI_WREADY  out  1  write data ready.
- S_AXI_BRESP/BVALID  out  2/1  write response.
- S_AXI_BREADY  in  1  write response ready.
- S_AXI_ARADDR/ARPROT/ARVALID  in  ADDR/3/1  read address channel; ARPROT is ignored.
- S_AXI_ARREADY  out  1  read address ready.
- S_AXI_RDATA/RRESP/RVALID  out  32/2/1  read data channel.
- S_AXI_RREADY  in  1  read data ready.
- cfg_reg0..cfg_reg3  out  32 each  register contents to the delay core.
- cfg_wr_pulse  out  4  one-cycle pulse; bit i marks a write to register i.

## Operation
- Address decode uses ADDR[4:2]. ADDR[1:0] is ignored. Words 0..3 are offsets 0x0, 0x4, 0x8 and 0xC. Words 4..7 are unmapped.
- Write side keeps two holding flags, aw_held and w_held, and latches address and data/strobe on their handshakes.
- AWREADY = !aw_held && !BVALID, registered. WREADY = !w_held && !BVALID, registered.
- The write commits on the edge where address and data are both available, each either handshaking on that edge or already held. At commit:
  - Bytes with WSTRB[k]=1 update; other bytes keep their value.
  - Both held flags clear.
  - BVALID sets.
  - For a mapped word, cfg_wr_pulse[i] is high for exactly the following cycle, even if WSTRB=0.
- BVALID holds until BREADY. While BVALID is high, AWREADY and WREADY are 0.
- Write FSM states: IDLE, HAVE_ADDR, HAVE_DATA, RESP.
  - IDLE→RESP: both channels handshake on the same edge.
  - IDLE→HAVE_ADDR: only AW handshakes. IDLE→HAVE_DATA: only W handshakes.
  - HAVE_ADDR or HAVE_DATA→RESP: the missing channel handshakes.
  - RESP→IDLE: BVALID && BREADY.
- Read FSM states: IDLE, RESP.
  - ARREADY = !RVALID, registered.
  - On AR handshake, RDATA is loaded from the addressed register and RVALID sets. Unmapped words read 0.
  - RDATA and RVALID hold until RREADY.
- Simultaneous write commit and read of the same word: the read returns the pre-write value.
- BRESP and RRESP are 2'b00 (OKAY), except as set under Configuration.

## Timing
- Reset values while ARESET is high:
  - all READY and VALID outputs 0;
  - BRESP, RRESP and RDATA 0;
  - cfg_reg0..3 0; cfg_wr_pulse 0;
  - FSMs in IDLE; held flags clear.
- AWREADY, WREADY and ARREADY rise on the first ACLK edge after ARESET deasserts.
- Write latency: AW and W handshaking together at edge N give cfg_regi updated, cfg_wr_pulse[i]=1 and BVALID=1 in cycle N+1.
- With BREADY=1 in cycle N+1, AWREADY and WREADY return in cycle N+2. Peak write rate is one per 2 cycles.
- Read latency: AR handshake at edge N gives RVALID and RDATA in cycle N+1. With RREADY=1 held, peak read rate is one per 2 cycles.
- Read and write paths are fully independent and may be active in the same cycle.
- ARESET asserted mid-transaction drops any outstanding write or read with no response, and clears all registers asynchronously.

## Configuration
- DELAY_AXI_SLVERR_EN defined:
  - Access to words 4..7 returns BRESP or RRESP = 2'b10 (SLVERR).
  - Writes to those words change nothing and pulse nothing; reads return RDATA=0.
- DELAY_AXI_SLVERR_EN undefined:
  - The same accesses return OKAY.
  - Writes are silently ignored; reads return 0.
- Mapped accesses return OKAY in both builds.

## Test plan
- Write 0x0101FFFF, 0xABCD0001, 0xDEAD0011 and 0xBEEF0011 to 0x0, 0x4, 0x8 and 0xC, each followed by a read of the same address.
  - Every BRESP and RRESP is 00.
  - Each read data equals the value written.
  - cfg_wr_pulse pulses 0001, 0010, 0100, 1000 in turn, each for one cycle.
- AW to 0x4 is issued 3 cycles before W 0x12345678.
  - AWREADY stays low after the AW handshake.
  - cfg_reg1 = 0x12345678 and BVALID rise the cycle after the W handshake.
  - W issued before AW gives the symmetric result.
- With cfg_reg2 = 0xDEAD0011, write 0xFFFFFFFF with WSTRB = 4'b0101.
  - cfg_reg2 becomes 0xDEFF00FF.
- Write 0x5A5A5A5A to 0x10 and read 0x1C.
  - Without the macro: BRESP 00, RRESP 00, RDATA 0, cfg_reg0..3 unchanged.
  - With DELAY_AXI_SLVERR_EN: BRESP 10, RRESP 10.
- Hold BREADY and RREADY low for 5 cycles.
  - BVALID, RVALID and RDATA stay stable.
  - AWREADY, WREADY and ARREADY stay 0.
- Assert ARESET while BVALID=1 with cfg_reg3 = 0xBEEF0011.
  - BVALID and cfg_reg3 drop to 0 immediately.
  - All READY outputs rise one edge after release.
